mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory port. Requester 0 is instruction fetch; requester 1 is load/store. The block grants the port round-robin and keeps at most one transaction outstanding. It drives `select_signal` for the 2:1 address/data mux in front of memory and routes the registered response back to the owning requester.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port: fetch (port 0) and
// load/store (port 1) take turns, with at most one memory transaction in flight.
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_0,
   input  logic                  req_valid_1,
   output logic                  req_ready_0,
   output logic                  req_ready_1,
   input  logic [ADDR_WIDTH-1:0] req_addr_0,
   input  logic [ADDR_WIDTH-1:0] req_addr_1,
   input  logic [DATA_WIDTH-1:0] req_wdata_0,
   input  logic [DATA_WIDTH-1:0] req_wdata_1,
   input  logic                  req_we_0,
   input  logic                  req_we_1,
   output logic                  resp_valid_0,
   output logic                  resp_valid_1,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  select_signal,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  anyValid;
   logic                  winner;

   // On a tie the port that did not win last time goes next.
   always_comb begin
      anyValid = req_valid_0 | req_valid_1;
      if (req_valid_0 && req_valid_1) begin
         winner = ~last_grant_q;
      end else begin
         winner = req_valid_1;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      rdata_d       = rdata_q;
      req_ready_0   = 1'b0;
      req_ready_1   = 1'b0;
      select_signal = owner_q;
      case (state_q)
         IDLE: begin
            if (anyValid) begin
               req_ready_0   = ~winner;
               req_ready_1   = winner;
               select_signal = winner;
               owner_d       = winner;
               last_grant_d  = winner;
               addr_d        = winner ? req_addr_1  : req_addr_0;
               wdata_d       = winner ? req_wdata_1 : req_wdata_0;
               we_d          = winner ? req_we_1    : req_we_0;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Completions are only meaningful here; anything earlier is stale.
            if (mem_resp_valid) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         rdata_q      <= rdata_d;
      end
   end

   assign mem_valid    = (state_q == ISSUE);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_we       = we_q;
   assign resp_rdata   = rdata_q;
   assign resp_valid_0 = (state_q == RESP) && !owner_q;
   assign resp_valid_1 = (state_q == RESP) && owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory,
// queueing the expected transaction at each grant and retiring it at the response strobe.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        req_valid_0, req_valid_1;
   logic        req_ready_0, req_ready_1;
   logic [31:0] req_addr_0, req_addr_1;
   logic [31:0] req_wdata_0, req_wdata_1;
   logic        req_we_0, req_we_1;
   logic        resp_valid_0, resp_valid_1;
   logic [31:0] resp_rdata;
   logic        select_signal;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] rdata;
   } expTxn_t;

   expTxn_t     sbQ[$];
   int          checkCount;
   int          errorCount;
   logic [31:0] lastRdata;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
      .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
      .req_we_0(req_we_0), .req_we_1(req_we_1),
      .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
      .resp_rdata(resp_rdata), .select_signal(select_signal),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] w0, input logic we0,
                                input logic v1, input logic [31:0] a1, input logic [31:0] w1, input logic we1);
      req_valid_0 = v0; req_addr_0 = a0; req_wdata_0 = w0; req_we_0 = we0;
      req_valid_1 = v1; req_addr_1 = a1; req_wdata_1 = w1; req_we_1 = we1;
   endtask

   task automatic applyReset();
      reset          = 1'b1;
      mem_ready      = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      reset     = 1'b0;
      lastRdata = 32'h0;
      #1;
      checkOutput("rstReady", {req_ready_1, req_ready_0}, 2'b00);
      checkOutput("rstResp", {resp_valid_1, resp_valid_0}, 2'b00);
      checkOutput("rstMemValid", mem_valid, 0);
      checkOutput("rstMemAddr", mem_addr, 0);
      checkOutput("rstMemWdata", mem_wdata, 0);
      checkOutput("rstMemWe", mem_we, 0);
      checkOutput("rstRdata", resp_rdata, 0);
      checkOutput("rstSelect", select_signal, 0);
   endtask

   // Runs one complete transaction starting in an IDLE cycle whose requester inputs are already set.
   task automatic serveOne(input logic port, input int readyDelay, input logic [31:0] rdata,
                           input logic holdValid, input logic staleInIssue);
      expTxn_t t;
      expTxn_t got;
      #1;
      checkOutput("idleResp", {resp_valid_1, resp_valid_0}, 2'b00);
      checkOutput("idleMemValid", mem_valid, 0);
      checkOutput("grantReady", {req_ready_1, req_ready_0}, port ? 2'b10 : 2'b01);
      checkOutput("idleSelect", select_signal, port);
      t.port  = port;
      t.addr  = port ? req_addr_1  : req_addr_0;
      t.wdata = port ? req_wdata_1 : req_wdata_0;
      t.we    = port ? req_we_1    : req_we_0;
      t.rdata = rdata;
      sbQ.push_back(t);
      tick();
      if (holdValid) begin
         if (port) begin
            req_addr_1 = req_addr_1 + 32'h10; req_wdata_1 = ~req_wdata_1;
         end else begin
            req_addr_0 = req_addr_0 + 32'h10; req_wdata_0 = ~req_wdata_0;
         end
      end else if (port) begin
         req_valid_1 = 1'b0;
      end else begin
         req_valid_0 = 1'b0;
      end
      for (int i = 0; i <= readyDelay; i++) begin
         mem_ready      = (i == readyDelay);
         mem_resp_valid = staleInIssue && (i == 0) && (readyDelay > 0);
         mem_rdata      = 32'hBAD0_BAD0;
         #1;
         checkOutput("issueValid", mem_valid, 1);
         checkOutput("issueAddr", mem_addr, sbQ[0].addr);
         checkOutput("issueWdata", mem_wdata, sbQ[0].wdata);
         checkOutput("issueWe", mem_we, sbQ[0].we);
         checkOutput("issueReady", {req_ready_1, req_ready_0}, 2'b00);
         checkOutput("issueSelect", select_signal, port);
         checkOutput("issueResp", {resp_valid_1, resp_valid_0}, 2'b00);
         checkOutput("issueRdataHeld", resp_rdata, lastRdata);
         tick();
      end
      mem_ready      = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      #1;
      checkOutput("waitMemValid", mem_valid, 0);
      checkOutput("waitReady", {req_ready_1, req_ready_0}, 2'b00);
      checkOutput("waitSelect", select_signal, port);
      checkOutput("waitRdataHeld", resp_rdata, lastRdata);
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h5A5A_5A5A;
      #1;
      got = sbQ.pop_front();
      checkOutput("respStrobe", {resp_valid_1, resp_valid_0}, got.port ? 2'b10 : 2'b01);
      checkOutput("respRdata", resp_rdata, got.rdata);
      checkOutput("respSelect", select_signal, got.port);
      checkOutput("respReady", {req_ready_1, req_ready_0}, 2'b00);
      lastRdata = got.rdata;
      tick();
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      applyReset();

      // Single fetch read with the fastest memory.
      applyStimulus(1, 32'h0000_0010, 32'h0, 0, 0, 0, 0, 0);
      serveOne(0, 0, 32'hDEAD_BEEF, 0, 0);

      // Tie straight out of reset: fetch first, then the load/store write.
      applyReset();
      applyStimulus(1, 32'h0000_0100, 32'h0, 0, 1, 32'h0000_0200, 32'h1234_5678, 1);
      serveOne(0, 0, 32'h1111_0000, 0, 0);
      serveOne(1, 0, 32'h2222_0000, 0, 0);

      // Both held valid: strict alternation, new fields presented after each grant.
      applyStimulus(1, 32'h0000_0300, 32'hA000_0000, 0, 1, 32'h0000_0400, 32'hB000_0000, 1);
      serveOne(0, 0, 32'h3333_0001, 1, 0);
      serveOne(1, 0, 32'h3333_0002, 1, 0);
      serveOne(0, 1, 32'h3333_0003, 1, 0);
      serveOne(1, 0, 32'h3333_0004, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Memory stalls three cycles in ISSUE.
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_0800, 32'hCAFE_F00D, 1);
      serveOne(1, 3, 32'h4444_4444, 0, 0);

      // Completion strobe while still in ISSUE must be ignored.
      applyStimulus(1, 32'h0000_0900, 32'h0, 0, 0, 0, 0, 0);
      serveOne(0, 2, 32'h5555_5555, 0, 1);

      // Reset during WAIT after a fetch grant, then a stale completion.
      applyStimulus(1, 32'h0000_0500, 32'h0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("rwGrant", {req_ready_1, req_ready_0}, 2'b01);
      tick();
      req_valid_0 = 1'b0;
      mem_ready   = 1'b1;
      #1;
      checkOutput("rwIssue", mem_valid, 1);
      tick();
      mem_ready = 1'b0;
      #1;
      checkOutput("rwWait", mem_valid, 0);
      reset = 1'b1;
      tick();
      reset          = 1'b0;
      lastRdata      = 32'h0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'hFFFF_FFFF;
      #1;
      checkOutput("rwNoResp", {resp_valid_1, resp_valid_0}, 2'b00);
      checkOutput("rwMemValid", mem_valid, 0);
      checkOutput("rwMemAddr", mem_addr, 0);
      checkOutput("rwSelect", select_signal, 0);
      tick();
      mem_resp_valid = 1'b0;
      #1;
      checkOutput("rwNoResp2", {resp_valid_1, resp_valid_0}, 2'b00);
      checkOutput("rwRdata", resp_rdata, 0);
      applyStimulus(1, 32'h0000_0600, 32'h0, 0, 1, 32'h0000_0700, 32'h7777_7777, 1);
      serveOne(0, 0, 32'h6666_6666, 0, 0);
      serveOne(1, 0, 32'h7777_0000, 0, 0);

      checkOutput("sbEmpty", sbQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
